// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_HILO_WRITE_EN to add the hilo_we_i/hilo_wd_i direct HI/LO write port (MTHI/MTLO).
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
`ifdef MDU_HILO_WRITE_EN
    input  logic [1:0]       hilo_we_i,
    input  logic [WIDTH-1:0] hilo_wd_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q;
    logic [CntW-1:0]    count_q;
    logic               is_div_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;
    logic               busy_q;

    // Operand decode at accept time
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        signed_op = ~op_i[0];
        a_neg     = signed_op & src_a_i[WIDTH-1];
        b_neg     = signed_op & src_b_i[WIDTH-1];
        a_mag     = a_neg ? -src_a_i : src_a_i;
        b_mag     = b_neg ? -src_b_i : src_b_i;
    end

    // One iteration step. Multiply keeps {partial product, remaining multiplier bits} in acc;
    // divide keeps {partial remainder, dividend bits shifting into quotient bits}.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] div_rem;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        // Only used when div_ge, where the true difference fits in WIDTH bits.
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
        if (is_div_q) begin
            acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the magnitude result
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        prod = acc_q;
        if (neg_a_q ^ neg_b_q) begin
            prod = -acc_q;
        end
        quo = acc_q[WIDTH-1:0];
        if (neg_a_q ^ neg_b_q) begin
            quo = -acc_q[WIDTH-1:0];
        end
        rem = acc_q[2*WIDTH-1:WIDTH];
        if (neg_a_q) begin
            rem = -acc_q[2*WIDTH-1:WIDTH];
        end
        if (is_div_q) begin
            // Divide by zero leaves |a| as remainder, which re-signs back to the original a.
            fix_lo = dbz_q ? {WIDTH{1'b1}} : quo;
            fix_hi = rem;
        end else begin
            fix_lo = prod[WIDTH-1:0];
            fix_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dbz_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        is_div_q <= op_i[1];
                        neg_a_q  <= a_neg;
                        neg_b_q  <= b_neg;
                        dbz_q    <= op_i[1] & (src_b_i == '0);
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                        if (op_i[1]) begin
                            acc_q  <= {{WIDTH{1'b0}}, a_mag};
                            opnd_q <= b_mag;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, b_mag};
                            opnd_q <= a_mag;
                        end
                    end
`ifdef MDU_HILO_WRITE_EN
                    else begin
                        if (hilo_we_i[1]) begin
                            hi_q <= hilo_wd_i;
                        end
                        if (hilo_we_i[0]) begin
                            lo_q <= hilo_wd_i;
                        end
                    end
`endif
                end
                StRun: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level behavioural model plus directed literals.
`timescale 1ns/1ps
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_HILO_WRITE_EN
    logic [1:0]  hilo_we = 2'd0;
    logic [31:0] hilo_wd = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (op),
        .src_a_i  (a),
        .src_b_i  (b),
`ifdef MDU_HILO_WRITE_EN
        .hilo_we_i(hilo_we),
        .hilo_wd_i(hilo_wd),
`endif
        .busy_o   (busy),
        .done_o   (done),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} computed with plain integer arithmetic.
    function automatic logic [63:0] model_op(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
        int    sx;
        int    sy;
        longint p;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin
                p = longint'(sx) * longint'(sy);
                return p;
            end
            2'd1: return {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Model: an accepted op completes W+1 edges later; nothing is accepted in between.
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        done_m;
    int          remain;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_m    <= 32'd0;
            lo_m    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            done_m  <= 1'b0;
            remain  <= 0;
        end else begin
            done_m <= 1'b0;
            if (remain > 0) begin
                remain <= remain - 1;
                if (remain == 1) begin
                    hi_m   <= pend_hi;
                    lo_m   <= pend_lo;
                    done_m <= 1'b1;
                end
            end else if (start) begin
                {pend_hi, pend_lo} <= model_op(op, a, b);
                remain             <= W + 1;
            end
`ifdef MDU_HILO_WRITE_EN
            else begin
                if (hilo_we[1]) hi_m <= hilo_wd;
                if (hilo_we[0]) lo_m <= hilo_wd;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check32("busy", {31'd0, busy}, {31'd0, remain > 0});
            check32("done", {31'd0, done}, {31'd0, done_m});
            check32("hi", hi, hi_m);
            check32("lo", lo, lo_m);
        end
    end

    // Called at a negedge: drives a request sampled by the next posedge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Waits for done; with noise, scrambles start/op/operands while the unit is busy.
    task automatic wait_done(input bit noise, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
            if (noise && i < 30) begin
                start = 1'($urandom);
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen within 40 cycles, required within 34");
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noise, output int cyc);
        start_op(o, x, y);
        wait_done(noise, cyc);
    endtask

    initial begin
        int cyc;
        logic [1:0] ro;
        logic [31:0] rx;
        logic [31:0] ry;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_done", {31'd0, done}, 32'd0);

        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, cyc);
        check32("multu_latency", cyc, 34);
        check32("multu_hi", hi, 32'h0000_0001);
        check32("multu_lo", lo, 32'hFFFF_FFFE);
        @(negedge clk);
        check32("done_one_cycle", {31'd0, done}, 32'd0);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, cyc);
        check32("mult_hi", hi, 32'hFFFF_FFFF);
        check32("mult_lo", lo, 32'hFFFF_FFEB);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
        check32("div_lo", lo, 32'hFFFF_FFFD);
        check32("div_hi", hi, 32'hFFFF_FFFF);
        run_op(2'd3, 32'd100, 32'd0, 1'b0, cyc);
        check32("divu0_lo", lo, 32'hFFFF_FFFF);
        check32("divu0_hi", hi, 32'd100);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
        check32("divovf_lo", lo, 32'h8000_0000);
        check32("divovf_hi", hi, 32'd0);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start_op(2'd3, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        start_op(2'd1, 32'd2, 32'd3);
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, cyc);
        check32("ignored_lo", lo, 32'd14);
        check32("ignored_hi", hi, 32'd2);
        run_op(2'd1, 32'd2, 32'd3, 1'b0, cyc);
        check32("back2back_latency", cyc, 34);
        check32("back2back_lo", lo, 32'd6);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start_op(2'd1, 32'h0001_2345, 32'h0000_0777);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check32("async_busy", {31'd0, busy}, 32'd0);
        check32("async_done", {31'd0, done}, 32'd0);
        check32("async_hi", hi, 32'd0);
        check32("async_lo", lo, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(2'd3, 32'd9, 32'd2, 1'b0, cyc);
        check32("post_reset_lo", lo, 32'd4);
        check32("post_reset_hi", hi, 32'd1);

`ifdef MDU_HILO_WRITE_EN
        @(negedge clk);
        hilo_wd = 32'h0000_1234;
        hilo_we = 2'b10;
        @(negedge clk);
        hilo_we = 2'b00;
        check32("mthi_hi", hi, 32'h0000_1234);
        check32("mthi_lo", lo, 32'd4);
        // start wins over a same-cycle write
        hilo_we = 2'b01;
        hilo_wd = 32'hDEAD_BEEF;
        run_op(2'd1, 32'd5, 32'd5, 1'b0, cyc);
        hilo_we = 2'b00;
        check32("start_priority_lo", lo, 32'd25);
`endif

        // Randomized ops with noise during RUN and random gaps (0 = start in done cycle)
        for (int n = 0; n < 30; n++) begin
            ro = 2'($urandom);
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 4) == 0) ry = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                rx = 32'h8000_0000;
                ry = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) ry = ry & 32'h0000_00FF;
            run_op(ro, rx, ry, 1'b1, cyc);
            repeat ($urandom_range(0, 2)) begin
`ifdef MDU_HILO_WRITE_EN
                hilo_we = 2'($urandom);
                hilo_wd = $urandom;
`endif
                @(negedge clk);
`ifdef MDU_HILO_WRITE_EN
                hilo_we = 2'b00;
`endif
            end
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
